// File: rtl/dmem_store_arbiter.sv
// In-order store buffer that shares the data-memory write port between the EVEN and ODD pipes.
// Drains one store per cycle, coalesces same-word bundles and forwards buffered data to loads.
module dmem_store_arbiter #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwriteEVEN,
  input  logic [31:0] dataadrEVEN,
  input  logic [31:0] writedataEVEN,
  input  logic        memwriteODD,
  input  logic [31:0] dataadrODD,
  input  logic [31:0] writedataODD,
  output logic        stall,
  output logic        fwdhitEVEN,
  output logic [31:0] fwddataEVEN,
  output logic        fwdhitODD,
  output logic [31:0] fwddataODD,
  output logic        memwe,
  output logic [31:0] memadr,
  output logic [31:0] memwd
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [31:0]     adr_q  [DEPTH];
  logic [31:0]     adr_d  [DEPTH];
  logic [31:0]     data_q [DEPTH];
  logic [31:0]     data_d [DEPTH];
  logic [PtrW-1:0] head_q, head_d, tail_q, tail_d, tail_p1, idx;
  logic [CntW-1:0] count_q, count_d;
  logic [1:0]      n_push;
  logic            pop, same_word;
  logic            bufhit_even, bufhit_odd;
  logic [31:0]     bufdata_even, bufdata_odd;

  // Stalling one entry early leaves room for a two-store bundle even without a pop.
  assign stall     = (count_q >= CntW'(DEPTH - 1));
  assign pop       = (count_q != '0);
  assign same_word = (dataadrEVEN[31:2] == dataadrODD[31:2]);
  assign tail_p1   = tail_q + PtrW'(1);

  assign memwe  = pop;
  assign memadr = pop ? adr_q[head_q] : '0;
  assign memwd  = pop ? data_q[head_q] : '0;

  always_comb begin
    adr_d  = adr_q;
    data_d = data_q;
    n_push = 2'd0;
    if (!stall) begin
      if (memwriteEVEN && memwriteODD && !same_word) begin
        adr_d[tail_q]   = dataadrEVEN;
        data_d[tail_q]  = writedataEVEN;
        adr_d[tail_p1]  = dataadrODD;
        data_d[tail_p1] = writedataODD;
        n_push          = 2'd2;
      end else if (memwriteODD) begin
        // Also covers the same-word bundle: the younger ODD store wins.
        adr_d[tail_q]  = dataadrODD;
        data_d[tail_q] = writedataODD;
        n_push         = 2'd1;
      end else if (memwriteEVEN) begin
        adr_d[tail_q]  = dataadrEVEN;
        data_d[tail_q] = writedataEVEN;
        n_push         = 2'd1;
      end
    end
    tail_d  = tail_q + PtrW'(n_push);
    head_d  = head_q + PtrW'(pop);
    count_d = count_q + CntW'(n_push) - CntW'(pop);
  end

  // Walk oldest to youngest so the youngest matching entry is the one left standing.
  always_comb begin
    idx          = head_q;
    bufhit_even  = 1'b0;
    bufdata_even = '0;
    bufhit_odd   = 1'b0;
    bufdata_odd  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PtrW'(i);
      if (CntW'(i) < count_q) begin
        if (adr_q[idx][31:2] == dataadrEVEN[31:2]) begin
          bufhit_even  = 1'b1;
          bufdata_even = data_q[idx];
        end
        if (adr_q[idx][31:2] == dataadrODD[31:2]) begin
          bufhit_odd  = 1'b1;
          bufdata_odd = data_q[idx];
        end
      end
    end
  end

  always_comb begin
    fwdhitEVEN  = 1'b0;
    fwddataEVEN = '0;
    fwdhitODD   = 1'b0;
    fwddataODD  = '0;
    if (!memwriteEVEN) begin
      fwdhitEVEN  = bufhit_even;
      fwddataEVEN = bufdata_even;
    end
    if (!memwriteODD) begin
      if (memwriteEVEN && same_word) begin
        fwdhitODD  = 1'b1;
        fwddataODD = writedataEVEN;
      end else begin
        fwdhitODD  = bufhit_odd;
        fwddataODD = bufdata_odd;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        adr_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      adr_q   <= adr_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: tb/tb_dmem_store_arbiter.sv
// Bench for dmem_store_arbiter: directed vector table, random traffic against a queue model,
// and an asynchronous reset in the middle of a drain.
module tb_dmem_store_arbiter;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        memwriteEVEN = 1'b0, memwriteODD = 1'b0;
  logic [31:0] dataadrEVEN = '0, writedataEVEN = '0, dataadrODD = '0, writedataODD = '0;
  logic        stall, fwdhitEVEN, fwdhitODD, memwe;
  logic [31:0] fwddataEVEN, fwddataODD, memadr, memwd;

  dmem_store_arbiter #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .memwriteEVEN(memwriteEVEN), .dataadrEVEN(dataadrEVEN), .writedataEVEN(writedataEVEN),
    .memwriteODD(memwriteODD), .dataadrODD(dataadrODD), .writedataODD(writedataODD),
    .stall(stall), .fwdhitEVEN(fwdhitEVEN), .fwddataEVEN(fwddataEVEN),
    .fwdhitODD(fwdhitODD), .fwddataODD(fwddataODD),
    .memwe(memwe), .memadr(memadr), .memwd(memwd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic ewe; logic [31:0] ea; logic [31:0] ed;
    logic owe; logic [31:0] oa; logic [31:0] od;
    logic st; logic we; logic [31:0] adr; logic [31:0] wd;
    logic he; logic [31:0] de; logic ho; logic [31:0] dod;
  } vec_t;

  typedef struct packed { logic [31:0] adr; logic [31:0] data; } ent_t;

  ent_t q[$];
  int   total = 0;
  int   bad = 0;
  int   writes_seen = 0;
  int   accepted = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ewe, input logic [31:0] ea, input logic [31:0] ed,
                       input logic owe, input logic [31:0] oa, input logic [31:0] od);
    memwriteEVEN = ewe; dataadrEVEN = ea; writedataEVEN = ed;
    memwriteODD = owe; dataadrODD = oa; writedataODD = od;
  endtask

  function automatic void model_fwd(input logic [31:0] a, output logic hit,
                                    output logic [31:0] d);
    hit = 1'b0;
    d = '0;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].adr[31:2] == a[31:2]) begin
        hit = 1'b1;
        d = q[i].data;
        break;
      end
    end
  endfunction

  // One cycle: drive, compare against the queue model, then advance the model past the edge.
  task automatic step(input logic ewe, input logic [31:0] ea, input logic [31:0] ed,
                      input logic owe, input logic [31:0] oa, input logic [31:0] od,
                      input string tag);
    logic        st_e, we_e, he, ho;
    logic [31:0] adr_e, wd_e, de, dod;
    @(posedge clk);
    #1;
    drive(ewe, ea, ed, owe, oa, od);
    #2;
    st_e  = (q.size() >= DEPTH - 1);
    we_e  = (q.size() != 0);
    adr_e = we_e ? q[0].adr : 32'h0;
    wd_e  = we_e ? q[0].data : 32'h0;
    he = 1'b0; de = '0; ho = 1'b0; dod = '0;
    if (!ewe) model_fwd(ea, he, de);
    if (!owe) begin
      if (ewe && ea[31:2] == oa[31:2]) begin
        ho = 1'b1;
        dod = ed;
      end else begin
        model_fwd(oa, ho, dod);
      end
    end
    chk({tag, " stall"}, {31'h0, stall}, {31'h0, st_e});
    chk({tag, " memwe"}, {31'h0, memwe}, {31'h0, we_e});
    chk({tag, " memadr"}, memadr, adr_e);
    chk({tag, " memwd"}, memwd, wd_e);
    chk({tag, " fwdhitEVEN"}, {31'h0, fwdhitEVEN}, {31'h0, he});
    chk({tag, " fwddataEVEN"}, fwddataEVEN, de);
    chk({tag, " fwdhitODD"}, {31'h0, fwdhitODD}, {31'h0, ho});
    chk({tag, " fwddataODD"}, fwddataODD, dod);
    if (memwe) writes_seen++;
    if (q.size() != 0) void'(q.pop_front());
    if (!st_e) begin
      if (ewe && owe && ea[31:2] == oa[31:2]) begin
        q.push_back('{adr: oa, data: od});
        accepted++;
      end else begin
        if (ewe) begin q.push_back('{adr: ea, data: ed}); accepted++; end
        if (owe) begin q.push_back('{adr: oa, data: od}); accepted++; end
      end
    end
  endtask

  vec_t tbl[17];

  initial begin
    tbl[0]  = '{1'b1, 32'h10, 32'hAAAA0001, 1'b0, 32'h0, 32'h0,
                1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0};
    tbl[1]  = '{1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0,
                1'b0, 1'b1, 32'h10, 32'hAAAA0001, 1'b0, 32'h0, 1'b0, 32'h0};
    tbl[2]  = '{1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0,
                1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0};
    tbl[3]  = '{1'b1, 32'h20, 32'h1, 1'b1, 32'h24, 32'h2,
                1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0};
    tbl[4]  = '{1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0,
                1'b0, 1'b1, 32'h20, 32'h1, 1'b0, 32'h0, 1'b0, 32'h0};
    tbl[5]  = '{1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0,
                1'b0, 1'b1, 32'h24, 32'h2, 1'b0, 32'h0, 1'b0, 32'h0};
    tbl[6]  = '{1'b1, 32'h30, 32'h5, 1'b1, 32'h33, 32'h6,
                1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0};
    tbl[7]  = '{1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0,
                1'b0, 1'b1, 32'h33, 32'h6, 1'b0, 32'h0, 1'b0, 32'h0};
    tbl[8]  = '{1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0,
                1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0};
    tbl[9]  = '{1'b1, 32'h50, 32'hB, 1'b1, 32'h40, 32'h7,
                1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0};
    tbl[10] = '{1'b1, 32'h40, 32'h8, 1'b1, 32'h60, 32'hC,
                1'b0, 1'b1, 32'h50, 32'hB, 1'b0, 32'h0, 1'b0, 32'h0};
    tbl[11] = '{1'b0, 32'h40, 32'h99, 1'b0, 32'h60, 32'h99,
                1'b1, 1'b1, 32'h40, 32'h7, 1'b1, 32'h8, 1'b1, 32'hC};
    tbl[12] = '{1'b1, 32'h44, 32'h9, 1'b0, 32'h44, 32'h0,
                1'b0, 1'b1, 32'h40, 32'h8, 1'b0, 32'h0, 1'b1, 32'h9};
    tbl[13] = '{1'b0, 32'h48, 32'h0, 1'b1, 32'h48, 32'hD,
                1'b0, 1'b1, 32'h60, 32'hC, 1'b0, 32'h0, 1'b0, 32'h0};
    tbl[14] = '{1'b0, 32'h48, 32'h0, 1'b0, 32'h70, 32'h0,
                1'b0, 1'b1, 32'h44, 32'h9, 1'b1, 32'hD, 1'b0, 32'h0};
    tbl[15] = '{1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0,
                1'b0, 1'b1, 32'h48, 32'hD, 1'b0, 32'h0, 1'b0, 32'h0};
    tbl[16] = '{1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0,
                1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0};

    #1;
    chk("reset memwe", {31'h0, memwe}, 32'h0);
    chk("reset stall", {31'h0, stall}, 32'h0);
    chk("reset memadr", memadr, 32'h0);
    chk("reset fwdhitODD", {31'h0, fwdhitODD}, 32'h0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Directed table
    for (int r = 0; r < 17; r++) begin
      @(posedge clk);
      #1;
      drive(tbl[r].ewe, tbl[r].ea, tbl[r].ed, tbl[r].owe, tbl[r].oa, tbl[r].od);
      #2;
      chk($sformatf("row%0d stall", r), {31'h0, stall}, {31'h0, tbl[r].st});
      chk($sformatf("row%0d memwe", r), {31'h0, memwe}, {31'h0, tbl[r].we});
      chk($sformatf("row%0d memadr", r), memadr, tbl[r].adr);
      chk($sformatf("row%0d memwd", r), memwd, tbl[r].wd);
      chk($sformatf("row%0d fwdhitEVEN", r), {31'h0, fwdhitEVEN}, {31'h0, tbl[r].he});
      chk($sformatf("row%0d fwddataEVEN", r), fwddataEVEN, tbl[r].de);
      chk($sformatf("row%0d fwdhitODD", r), {31'h0, fwdhitODD}, {31'h0, tbl[r].ho});
      chk($sformatf("row%0d fwddataODD", r), fwddataODD, tbl[r].dod);
    end

    // Random traffic; buffer is empty after the table, matching the empty model queue.
    writes_seen = 0;
    accepted = 0;
    for (int c = 0; c < 400; c++) begin
      logic [31:0] ea, oa;
      ea = {27'h0, 3'($urandom_range(0, 7)), 2'($urandom)};
      oa = {27'h0, 3'($urandom_range(0, 7)), 2'($urandom)};
      step(1'($urandom_range(0, 9) < 7), ea, $urandom,
           1'($urandom_range(0, 9) < 7), oa, $urandom, $sformatf("rnd%0d", c));
    end
    for (int c = 0; c < DEPTH + 2; c++) begin
      step(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, $sformatf("drain%0d", c));
    end
    chk("writes vs accepted", writes_seen, accepted);

    // Reset in the middle of a drain
    step(1'b1, 32'h100, 32'h1, 1'b1, 32'h104, 32'h2, "pre0");
    step(1'b1, 32'h108, 32'h3, 1'b1, 32'h10C, 32'h4, "pre1");
    @(posedge clk);
    #1 drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    #1;
    chk("full before reset stall", {31'h0, stall}, 32'h1);
    chk("full before reset memwe", {31'h0, memwe}, 32'h1);
    reset = 1'b1;
    #1;
    chk("async reset memwe", {31'h0, memwe}, 32'h0);
    chk("async reset stall", {31'h0, stall}, 32'h0);
    chk("async reset memadr", memadr, 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    q.delete();
    for (int c = 0; c < 5; c++) begin
      step(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, $sformatf("postrst%0d", c));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
